// File: rtl/scope_capture_ctrl.sv
// Capture sequencer for the scope sample FIFO: sliding pre-trigger window,
// level/slope trigger, post-trigger fill and valid/ready drain of the record.
module scope_capture_ctrl #(
    parameter int DATA_W  = 8,
    parameter int DEPTH_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic               abort,
    input  logic               force_trig,
    input  logic [DATA_W-1:0]  trig_level,
    input  logic               trig_slope,
    input  logic [DEPTH_W-1:0] pre_len,
    input  logic [DEPTH_W-1:0] post_len,
    input  logic               ad_valid,
    input  logic [DATA_W-1:0]  ad_data,
    output logic               fifo_wr_en,
    output logic [DATA_W-1:0]  fifo_wr_data,
    input  logic               fifo_full,
    output logic               fifo_rd_en,
    input  logic [DATA_W-1:0]  fifo_rd_data,
    input  logic               fifo_empty,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy,
    output logic               triggered,
    output logic               done,
    output logic               overflow,
    output logic [2:0]         state
);

    // state | meaning
    // IDLE  | waiting for arm
    // PRE   | filling the pre-trigger window
    // ARMED | window full, sliding; waiting for trigger
    // POST  | writing post-trigger samples
    // READ  | draining the record to the output stream
    // DONE  | record delivered; may re-arm
    // FLUSH | abort: emptying the FIFO, data discarded
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_READ  = 3'd4,
        S_DONE  = 3'd5,
        S_FLUSH = 3'd6
    } state_t;

    localparam logic [DEPTH_W-1:0] CNT_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [DEPTH_W-1:0] pre_len_q, pre_len_d;
    logic [DEPTH_W-1:0] post_eff_q, post_eff_d;
    logic [DEPTH_W-1:0] fill_q, fill_d;
    logic [DEPTH_W-1:0] post_cnt_q, post_cnt_d;
    logic [DEPTH_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0]  prev_q, prev_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               prev_valid_q, prev_valid_d;
    logic               inflight_q, inflight_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               triggered_q, triggered_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               wr_req;
    logic               rd_req;
    logic               rise_x;
    logic               fall_x;
    logic               trig_hit;
    logic [DEPTH_W:0]   rem_init;

    assign rise_x   = (prev_q < trig_level) && (ad_data >= trig_level);
    assign fall_x   = (prev_q > trig_level) && (ad_data <= trig_level);
    assign trig_hit = ad_valid && (force_trig || (prev_valid_q && (trig_slope ? fall_x : rise_x)));
    assign rem_init = {1'b0, pre_len_q} + {1'b0, post_eff_q};

    always_comb begin
        state_d      = state_q;
        pre_len_d    = pre_len_q;
        post_eff_d   = post_eff_q;
        fill_d       = fill_q;
        post_cnt_d   = post_cnt_q;
        rem_d        = rem_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        triggered_d  = triggered_q;
        overflow_d   = overflow_q;
        inflight_d   = 1'b0;
        wr_req       = 1'b0;
        rd_req       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d      = S_PRE;
                    pre_len_d    = pre_len;
                    post_eff_d   = (post_len == '0) ? CNT_ONE : post_len;
                    fill_d       = '0;
                    post_cnt_d   = '0;
                    triggered_d  = 1'b0;
                    overflow_d   = 1'b0;
                    prev_valid_d = 1'b0;
                end
            end
            S_PRE: begin
                if (pre_len_q == '0) begin
                    state_d = S_ARMED;
                end else if (ad_valid) begin
                    wr_req = 1'b1;
                    fill_d = fill_q + CNT_ONE;
                    if (fill_q + CNT_ONE == pre_len_q) state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (ad_valid) begin
                    wr_req       = 1'b1;
                    prev_d       = ad_data;
                    prev_valid_d = 1'b1;
                    if (trig_hit) begin
                        triggered_d = 1'b1;
                        post_cnt_d  = CNT_ONE;
                        rem_d       = rem_init;
                        state_d     = (post_eff_q <= CNT_ONE) ? S_READ : S_POST;
                    end else if (pre_len_q != '0) begin
                        // keep the window at pre_len samples by dropping the oldest
                        rd_req = 1'b1;
                    end
                end
            end
            S_POST: begin
                if (ad_valid) begin
                    wr_req     = 1'b1;
                    post_cnt_d = post_cnt_q + CNT_ONE;
                    if (post_cnt_q + CNT_ONE == post_eff_q) begin
                        rem_d   = rem_init;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                rd_req = (rem_q != '0) && !fifo_empty && !inflight_q && (!out_valid_q || out_ready);
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) state_d = S_DONE;
                end
                if (inflight_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = fifo_rd_data;
                    out_last_d  = (rem_q == '0);
                end
                if (rd_req) rem_d = rem_q - 1'b1;
                inflight_d = rd_req;
            end
            S_FLUSH: begin
                rd_req      = !fifo_empty;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                if (fifo_empty) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d      = S_FLUSH;
            wr_req       = 1'b0;
            rd_req       = 1'b0;
            inflight_d   = 1'b0;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            triggered_d  = 1'b0;
            prev_valid_d = 1'b0;
        end

        if (wr_req && fifo_full) overflow_d = 1'b1;

        busy_d = !(state_d == S_IDLE || state_d == S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pre_len_q    <= '0;
            post_eff_q   <= '0;
            fill_q       <= '0;
            post_cnt_q   <= '0;
            rem_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            triggered_q  <= 1'b0;
            overflow_q   <= 1'b0;
            inflight_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_len_q    <= pre_len_d;
            post_eff_q   <= post_eff_d;
            fill_q       <= fill_d;
            post_cnt_q   <= post_cnt_d;
            rem_q        <= rem_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            triggered_q  <= triggered_d;
            overflow_q   <= overflow_d;
            inflight_q   <= inflight_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign fifo_wr_en   = wr_req && !fifo_full;
    assign fifo_wr_data = ad_data;
    assign fifo_rd_en   = rd_req;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign busy         = busy_q;
    assign triggered    = triggered_q;
    assign done         = done_q;
    assign overflow     = overflow_q;
    assign state        = state_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Bench for scope_capture_ctrl: behavioural FIFO, record model derived from the
// trigger rules, randomized sample streams and output backpressure.
module tb_scope_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic       force_trig = 1'b0;
    logic [7:0] trig_level = 8'h00;
    logic       trig_slope = 1'b0;
    logic [9:0] pre_len = 10'd0;
    logic [9:0] post_len = 10'd0;
    logic       ad_valid = 1'b0;
    logic [7:0] ad_data = 8'h00;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic       fifo_full;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_empty;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       triggered;
    logic       done;
    logic       overflow;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    scope_capture_ctrl #(.DATA_W(8), .DEPTH_W(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .abort        (abort),
        .force_trig   (force_trig),
        .trig_level   (trig_level),
        .trig_slope   (trig_slope),
        .pre_len      (pre_len),
        .post_len     (post_len),
        .ad_valid     (ad_valid),
        .ad_data      (ad_data),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .busy         (busy),
        .triggered    (triggered),
        .done         (done),
        .overflow     (overflow),
        .state        (state)
    );

    always #5 clk = ~clk;

    // FIFO model, not reset by rst_n; capacity can be shrunk per test
    int         fifo_cap = 1024;
    logic [7:0] fq[$];
    int         fcount = 0;
    int         pop_total = 0;

    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) begin
            fifo_rd_data <= fq.pop_front();
            pop_total++;
        end
        if (fifo_wr_en && fq.size() < fifo_cap) fq.push_back(fifo_wr_data);
        fcount <= fq.size();
    end

    assign fifo_empty = (fcount == 0);
    assign fifo_full  = (fcount >= fifo_cap);

    logic [7:0] samp[$];
    bit         frc[$];
    logic [7:0] exp_rec[$];

    // Index of the triggering sample in the valid stream, or -1.
    function automatic int find_trig(input int pre, input logic [7:0] lvl, input bit slope);
        for (int i = pre; i < samp.size(); i++) begin
            if (frc[i]) return i;
            if (i > pre) begin
                if (!slope && samp[i-1] < lvl && samp[i] >= lvl) return i;
                if (slope && samp[i-1] > lvl && samp[i] <= lvl) return i;
            end
        end
        return -1;
    endfunction

    function automatic void build_expected(input int t, input int pre, input int post);
        int pe;
        pe = (post == 0) ? 1 : post;
        exp_rec.delete();
        for (int i = t - pre; i < t + pe; i++) exp_rec.push_back(samp[i]);
    endfunction

    task automatic do_arm(input int pre, input int post, input logic [7:0] lvl, input bit slope);
        @(negedge clk);
        pre_len    = 10'(pre);
        post_len   = 10'(post);
        trig_level = lvl;
        trig_slope = slope;
        force_trig = 1'b0;
        arm        = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic drive_samples(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                ad_valid = 1'b0;
            end else begin
                ad_valid   = 1'b1;
                ad_data    = samp[k];
                force_trig = frc[k];
                k++;
            end
        end
        @(negedge clk);
        ad_valid   = 1'b0;
        force_trig = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while (state !== 3'd0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (state !== 3'd0) begin
            n_bad++;
            $display("FAIL %s_idle_timeout: state=%0d, need 0", tag, state);
        end
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic collect(input int rdy_pct, input string tag);
        logic [7:0] got_d[$];
        bit         got_l[$];
        bit         stall;
        bit         fin;
        logic [7:0] held_d;
        logic       held_l;
        int         cyc;
        int         n;
        stall = 0;
        fin   = 0;
        cyc   = 0;
        held_d = 8'h00;
        held_l = 1'b0;
        while (!fin && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
                    n_bad++;
                    $display("FAIL %s_hold: got v=%b d=%h l=%b, need v=1 d=%h l=%b",
                             tag, out_valid, out_data, out_last, held_d, held_l);
                end
            end
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            stall = 0;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    got_d.push_back(out_data);
                    got_l.push_back(out_last);
                    if (out_last === 1'b1) fin = 1;
                end else begin
                    stall  = 1;
                    held_d = out_data;
                    held_l = out_last;
                end
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (!fin) begin
            n_bad++;
            $display("FAIL %s_timeout: no last beat after %0d cycles, beats=%0d", tag, cyc, got_d.size());
        end
        n_cmp++;
        if (got_d.size() != exp_rec.size()) begin
            n_bad++;
            $display("FAIL %s_count: got %0d beats, need %0d", tag, got_d.size(), exp_rec.size());
        end
        n = (got_d.size() < exp_rec.size()) ? got_d.size() : exp_rec.size();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (got_d[i] !== exp_rec[i]) begin
                n_bad++;
                $display("FAIL %s_data[%0d]: got %h, need %h", tag, i, got_d[i], exp_rec[i]);
            end
            n_cmp++;
            if (got_l[i] != (i == exp_rec.size() - 1)) begin
                n_bad++;
                $display("FAIL %s_last[%0d]: got %b, need %b", tag, i, got_l[i], (i == exp_rec.size() - 1));
            end
        end
        n_cmp++;
        if (done !== 1'b1 || state !== 3'd5 || busy !== 1'b0 || fifo_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_end: done=%b state=%0d busy=%b empty=%b, need 1/5/0/1",
                     tag, done, state, busy, fifo_empty);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({fifo_wr_en, fifo_rd_en, out_valid, out_last, busy, triggered, done, overflow} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_flags: got wr=%b rd=%b v=%b l=%b busy=%b trg=%b done=%b ovf=%b, need all 0",
                     fifo_wr_en, fifo_rd_en, out_valid, out_last, busy, triggered, done, overflow);
        end
        n_cmp++;
        if (state !== 3'd0 || out_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_state: got state=%0d data=%h, need 0/00", state, out_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ramp();
        int t;
        samp.delete();
        frc.delete();
        for (int i = 0; i < 32; i++) begin
            samp.push_back(8'(8'h70 + i));
            frc.push_back(1'b0);
        end
        t = find_trig(4, 8'h80, 1'b0);
        build_expected(t, 4, 4);
        do_arm(4, 4, 8'h80, 1'b0);
        drive_samples(t + 4);
        n_cmp++;
        if (triggered !== 1'b1) begin
            n_bad++;
            $display("FAIL ramp_triggered: got %b, need 1", triggered);
        end
        collect(100, "ramp");
    endtask

    task automatic test_force_single();
        samp.delete();
        frc.delete();
        for (int i = 0; i < 5; i++) begin
            samp.push_back(8'($urandom_range(0, 255)));
            frc.push_back(1'b1);
        end
        build_expected(find_trig(0, 8'h80, 1'b0), 0, 0);
        do_arm(0, 0, 8'h80, 1'b0);
        drive_samples(1);
        collect(50, "force1");
    endtask

    task automatic test_slopes();
        logic [7:0] fall_v[6];
        logic [7:0] rise_v[8];
        int t;
        fall_v = '{8'h60, 8'h61, 8'h50, 8'h40, 8'h22, 8'h23};
        rise_v = '{8'h10, 8'h11, 8'h41, 8'h40, 8'h3F, 8'h40, 8'h55, 8'h56};
        samp.delete();
        frc.delete();
        for (int i = 0; i < 6; i++) begin
            samp.push_back(fall_v[i]);
            frc.push_back(1'b0);
        end
        t = find_trig(2, 8'h40, 1'b1);
        build_expected(t, 2, 2);
        do_arm(2, 2, 8'h40, 1'b1);
        drive_samples(t + 2);
        collect(100, "falling");
        samp.delete();
        frc.delete();
        for (int i = 0; i < 8; i++) begin
            samp.push_back(rise_v[i]);
            frc.push_back(1'b0);
        end
        t = find_trig(2, 8'h40, 1'b0);
        build_expected(t, 2, 2);
        do_arm(2, 2, 8'h40, 1'b0);
        drive_samples(t + 2);
        collect(70, "rising_no_false");
    endtask

    task automatic test_random();
        int pre, post, t, pe;
        logic [7:0] lvl;
        bit slope;
        for (int it = 0; it < 6; it++) begin
            pre   = $urandom_range(0, 20);
            post  = $urandom_range(0, 20);
            lvl   = 8'($urandom_range(32, 224));
            slope = 1'($urandom_range(0, 1));
            samp.delete();
            frc.delete();
            for (int i = 0; i < 200; i++) begin
                samp.push_back(8'($urandom_range(0, 255)));
                frc.push_back(i == 150);
            end
            t  = find_trig(pre, lvl, slope);
            pe = (post == 0) ? 1 : post;
            build_expected(t, pre, post);
            do_arm(pre, post, lvl, slope);
            drive_samples(t + pe);
            collect(60, "random");
        end
    endtask

    task automatic test_backpressure();
        int t, fi;
        samp.delete();
        frc.delete();
        fi = $urandom_range(100, 400);
        for (int i = 0; i < 1400; i++) begin
            samp.push_back(8'($urandom_range(0, 255)));
            frc.push_back(i == fi);
        end
        t = find_trig(100, 8'h80, 1'b0);
        build_expected(t, 100, 900);
        do_arm(100, 900, 8'h80, 1'b0);
        drive_samples(t + 900);
        collect(30, "backpressure");
    endtask

    task automatic test_abort();
        int  base;
        bit  saw_valid;
        int  cyc;
        samp.delete();
        frc.delete();
        for (int i = 0; i < 60; i++) begin
            samp.push_back(8'($urandom_range(0, 255)));
            frc.push_back(i == 10);
        end
        do_arm(10, 100, 8'h80, 1'b0);
        drive_samples(37);
        n_cmp++;
        if (state !== 3'd3) begin
            n_bad++;
            $display("FAIL abort_in_post: state=%0d, need 3", state);
        end
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        n_cmp++;
        if (state !== 3'd3 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL arm_ignored: state=%0d busy=%b, need 3/1", state, busy);
        end
        base = pop_total;
        saw_valid = 0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        cyc = 0;
        while (state !== 3'd0 && cyc < 200) begin
            if (out_valid === 1'b1) saw_valid = 1;
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (pop_total - base != 37) begin
            n_bad++;
            $display("FAIL abort_reads: got %0d, need 37", pop_total - base);
        end
        n_cmp++;
        if (saw_valid || state !== 3'd0 || fifo_empty !== 1'b1 || triggered !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_end: saw_valid=%b state=%0d empty=%b trg=%b, need 0/0/1/0",
                     saw_valid, state, fifo_empty, triggered);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] got[$];
        samp.delete();
        frc.delete();
        for (int i = 0; i < 40; i++) begin
            samp.push_back(8'($urandom_range(0, 255)));
            frc.push_back(i == 4);
        end
        fifo_cap = 16;
        do_arm(4, 30, 8'h80, 1'b0);
        drive_samples(34);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set: got %b, need 1", overflow);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) got.push_back(out_data);
        end
        out_ready = 1'b0;
        n_cmp++;
        if (got.size() != 16) begin
            n_bad++;
            $display("FAIL ovf_beats: got %0d, need 16", got.size());
        end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_cmp++;
            if (got[i] !== samp[i]) begin
                n_bad++;
                $display("FAIL ovf_data[%0d]: got %h, need %h", i, got[i], samp[i]);
            end
        end
        pulse_abort();
        wait_idle("ovf");
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_sticky: got %b, need 1", overflow);
        end
        fifo_cap = 1024;
        do_arm(4, 4, 8'h80, 1'b0);
        n_cmp++;
        if (overflow !== 1'b0 || state !== 3'd1) begin
            n_bad++;
            $display("FAIL ovf_clear: ovf=%b state=%0d, need 0/1", overflow, state);
        end
    endtask

    task automatic test_reset_mid_capture();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ad_valid = 1'b1;
            ad_data  = 8'(8'hA0 + i);
        end
        @(negedge clk);
        ad_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, busy, triggered, done, overflow, fifo_rd_en} !== 6'b0 || state !== 3'd0) begin
            n_bad++;
            $display("FAIL midrst_values: v=%b busy=%b trg=%b done=%b ovf=%b rd=%b state=%0d, need zeros",
                     out_valid, busy, triggered, done, overflow, fifo_rd_en, state);
        end
        n_cmp++;
        if (fifo_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_stale: empty=%b, need 0", fifo_empty);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_abort();
        wait_idle("midrst");
        n_cmp++;
        if (fifo_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_flushed: empty=%b, need 1", fifo_empty);
        end
        test_ramp();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_force_single();
        test_slopes();
        test_random();
        test_backpressure();
        test_abort();
        test_overflow();
        test_reset_mid_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
